// File: rtl/key_event_decoder_if.sv
// Key-channel bundle between the raw push-buttons and the debounced event outputs.
// release_p carries the release pulse because "release" is a reserved word.
interface key_event_decoder_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_p;
  logic [NUM_KEYS-1:0] repeat_p;
  logic                any_press;

  modport master (
    output key_n,
    input  pressed, press, release_p, repeat_p, any_press
  );

  modport slave (
    input  key_n,
    output pressed, press, release_p, repeat_p, any_press
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns bouncy, asynchronous active-low push-buttons into a clean debounced level
// plus one-cycle press / release / auto-repeat pulses, one independent channel per key.
module key_event_decoder #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  key_event_decoder_if.slave   kbus
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } state_e;

  logic [NUM_KEYS-1:0] pressed_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] release_vec;
  logic [NUM_KEYS-1:0] repeat_vec;
  logic [NUM_KEYS-1:0] press_next_vec;
  logic                any_press_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic              s1_q, s2_q;
    logic              down;
    state_e            state_q, state_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              first_q, first_d;
    logic              pressed_q, pressed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;

    // Only the second synchronizer stage is ever looked at; s1 may be metastable.
    assign down = ~s2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1_q      <= 1'b1;
        s2_q      <= 1'b1;
        state_q   <= ST_IDLE;
        db_q      <= '0;
        hold_q    <= '0;
        first_q   <= 1'b0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        s1_q      <= kbus.key_n[i];
        s2_q      <= s1_q;
        state_q   <= state_d;
        db_q      <= db_d;
        hold_q    <= hold_d;
        first_q   <= first_d;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
      state_d   = state_q;
      db_d      = db_q;
      hold_d    = hold_q;
      first_d   = first_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (down) begin
            state_d = ST_PRESS_DB;
            db_d    = '0;
          end
        end

        ST_PRESS_DB: begin
          if (!down) begin
            state_d = ST_IDLE;
          end else if (db_q == DB_LAST) begin
            state_d   = ST_HELD;
            press_d   = 1'b1;
            pressed_d = 1'b1;
            hold_d    = '0;
            first_d   = 1'b1;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end

        ST_HELD: begin
          if (!down) begin
            state_d = ST_RELEASE_DB;
            db_d    = '0;
          end else if (first_q && hold_q == DELAY_LAST) begin
            repeat_d = 1'b1;
            hold_d   = '0;
            first_d  = 1'b0;
          end else if (!first_q && hold_q == PERIOD_LAST) begin
            repeat_d = 1'b1;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end

        ST_RELEASE_DB: begin
          // A re-press during release debounce restarts the repeat timer from scratch.
          if (down) begin
            state_d = ST_HELD;
            hold_d  = '0;
            first_d = 1'b1;
          end else if (db_q == DB_LAST) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
            pressed_d = 1'b0;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    assign pressed_vec[i]    = pressed_q;
    assign press_vec[i]      = press_q;
    assign release_vec[i]    = release_q;
    assign repeat_vec[i]     = repeat_q;
    assign press_next_vec[i] = press_d;
  end

  // Built from the next-state press terms so it lands on the same edge as press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_next_vec;
    end
  end

  assign kbus.pressed   = pressed_vec;
  assign kbus.press     = press_vec;
  assign kbus.release_p = release_vec;
  assign kbus.repeat_p  = repeat_vec;
  assign kbus.any_press = any_press_q;

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Input-side counterpart to the LED/FSM output path: turns raw DE1-SoC push-buttons (KEY, active-low, bouncy, asynchronous) into clean, clock-domain-safe events for game FSMs (e.g. flap, start).
- Per key: 2-FF synchronizer, debounce state machine, stable level, one-cycle press/release pulses, and auto-repeat pulses while held.
- Instantiated in the top level on the same clock as the game logic.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, cycles a new level must be stable before acceptance (10 ms at 50 MHz). Minimum 2.
- REPEAT_DELAY, 25000000, held cycles from press acceptance to the first repeat pulse. Minimum 2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses. Minimum 2.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset; wired directly to KEY[0].
- key_n  in  NUM_KEYS  raw buttons, 0 = pressed, asynchronous to clk.
- pressed  out  NUM_KEYS  debounced level, 1 = held.
- press  out  NUM_KEYS  1-cycle pulse on accepted press.
- release  out  NUM_KEYS  1-cycle pulse on accepted release.
- repeat_p  out  NUM_KEYS  1-cycle auto-repeat pulse while held.
- any_press  out  1  OR of press, registered in the same cycle as press.

Behaviour:
- Reset:
  - Asynchronous on reset = 0.
  - Synchronizer flops go to 1 (released).
  - FSM goes to IDLE; all counters go to 0.
  - All outputs go to 0.
  - Deasserting reset while a key is held produces a normal debounced press; no spurious release.
- Synchronizer: s1 <= key_n[i]; s2 <= s1. The FSM uses only s2, and "down" means s2 = 0.
- Per-key FSM, all keys independent; simultaneous events on different keys all pulse in the same cycle:
  - IDLE: down -> PRESS_DB, db_cnt = 0.
  - PRESS_DB:
    - Up -> IDLE; this is a bounce, no pulse.
    - Else, if db_cnt = DEBOUNCE_CYCLES-1 -> HELD: press = 1, pressed = 1, hold_cnt = 0, first = 1.
    - Else db_cnt++.
  - HELD:
    - Up -> RELEASE_DB, db_cnt = 0.
    - Else, if first and hold_cnt = REPEAT_DELAY-1: repeat_p = 1, hold_cnt = 0, first = 0.
    - Else, if not first and hold_cnt = REPEAT_PERIOD-1: repeat_p = 1, hold_cnt = 0.
    - Else hold_cnt++.
  - RELEASE_DB:
    - Down -> HELD: hold_cnt = 0, first = 1, pressed stays 1, no pulse (the repeat timer restarts).
    - Else, if db_cnt = DEBOUNCE_CYCLES-1 -> IDLE: release = 1, pressed = 0.
    - Else db_cnt++.
- Latency:
  - Let edge 0 be the first posedge sampling key_n low, with key_n then held steady.
  - press and pressed are high after edge DEBOUNCE_CYCLES+2.
  - Release is symmetric: release is high after edge DEBOUNCE_CYCLES+2 from the first high sample.
- Pulse rules:
  - press, release and repeat_p are exactly 1 cycle, registered, and mutually exclusive per key.
  - A bounce sampled on the final debounce cycle (db_cnt = D-1) cancels the transition.
- Widths: db_cnt is $clog2(DEBOUNCE_CYCLES) bits; hold_cnt is $clog2 of max(REPEAT_DELAY, REPEAT_PERIOD) bits. Counters never wrap; they reload explicitly.
- KEY[0] doubles as reset, so its channel stays at IDLE while held; the channel is still implemented for uniformity.

Test Plan (simulation params DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4):
- Reset pulse with key_n=4'b1111 -> all outputs 0. Drop key_n[1] at edge 0 and hold -> press[1] and any_press high for exactly the cycle after edge 6; pressed[1]=1 from then on.
- key_n[2] low for 3 cycles, then high -> no press, pressed[2] stays 0. Low for 5 cycles with a 1-cycle high glitch at the 4th -> no press until 4 stable low samples.
- Hold key_n[3] -> press after edge 6, repeat_p[3] pulses after edges 14, 18, 22. Release at edge 24 -> release[3] pulse after edge 30, pressed[3]=0, no further repeat.
- key_n[1] and key_n[3] drop on the same edge -> press[1] and press[3] pulse in the same cycle; any_press is a single 1-cycle pulse.
- Held key: release glitch of 2 cycles -> no release pulse, pressed stays 1, first repeat_p 8 held cycles after re-entry to HELD.
- Assert reset mid-PRESS_DB and mid-HELD -> all outputs 0 immediately (asynchronously). Deassert with the key still low -> press pulses again after D+2 edges.
